// File: rtl/universal_counter.sv
// Single-digit modulo counter with carry-in / carry-out for cascading.
// Counts 0..P_BASE_NUMBER on rising clk while c_in is high, then wraps to 0.
// c_out is high in the cycle that will wrap, so it can feed the next digit.
//
// Optional build macro UNIVERSAL_COUNTER_CHECK_EN adds an elaboration-time
// range check on P_BASE_NUMBER and simulation assertions on the state and
// carry. With the macro undefined, no checks are compiled in.

module universal_counter #(
  parameter int unsigned P_BASE_NUMBER = 9
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       c_in,
  output logic       c_out,
  output logic [3:0] q
);

  // Terminal count narrowed to the state width; legal values fit in 4 bits.
  localparam logic [3:0] TermQ = P_BASE_NUMBER[3:0];

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next count: hold without carry-in; wrap at or beyond the terminal value.
  // The ">=" also recovers an out-of-range state on the next counted edge.
  always_comb begin
    q_d = q_q;
    if (c_in) begin
      if (q_q >= TermQ) begin
        q_d = '0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  // Combinational so the next digit advances on the same edge this one wraps.
  assign c_out = c_in & (q_q == TermQ);

`ifdef UNIVERSAL_COUNTER_CHECK_EN
  if (P_BASE_NUMBER < 1 || P_BASE_NUMBER > 15) begin : gen_bad_base
    $error("universal_counter: P_BASE_NUMBER must be in 1..15");
  end

  // State never leaves 0..P_BASE_NUMBER while out of reset.
  q_range_a : assert property (@(posedge clk) disable iff (!n_reset) q_q <= TermQ);

  // Carry-out only ever asserts together with carry-in.
  c_out_gated_a : assert property (@(posedge clk) disable iff (!n_reset) !(c_out && !c_in));
`endif

endmodule

// File: tb/tb_universal_counter.sv
// Directed self-checking bench for universal_counter: a base-9 digit, a
// base-5 digit sharing its carry-in, and a two-digit base-9 cascade.

module tb_universal_counter;

  logic       clk;
  logic       n_reset;
  logic       c_in;
  logic       casc_en;

  logic       c_out;
  logic [3:0] q;
  logic       b5_c_out;
  logic [3:0] b5_q;
  logic       lo_c_out;
  logic [3:0] lo_q;
  logic       hi_c_out;
  logic [3:0] hi_q;

  int n_tests;
  int n_fail;

  universal_counter #(.P_BASE_NUMBER(9)) u_dut (
    .clk     (clk),
    .n_reset (n_reset),
    .c_in    (c_in),
    .c_out   (c_out),
    .q       (q)
  );

  universal_counter #(.P_BASE_NUMBER(5)) u_b5 (
    .clk     (clk),
    .n_reset (n_reset),
    .c_in    (c_in),
    .c_out   (b5_c_out),
    .q       (b5_q)
  );

  universal_counter #(.P_BASE_NUMBER(9)) u_lo (
    .clk     (clk),
    .n_reset (n_reset),
    .c_in    (casc_en),
    .c_out   (lo_c_out),
    .q       (lo_q)
  );

  universal_counter #(.P_BASE_NUMBER(9)) u_hi (
    .clk     (clk),
    .n_reset (n_reset),
    .c_in    (lo_c_out),
    .c_out   (hi_c_out),
    .q       (hi_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset low across a full clock period, releasing while clk is low.
  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    c_in    = 1'b1;
    casc_en = 1'b1;
    @(negedge clk);
    n_reset = 1'b0;
    step();
    step();
    n_tests++;
    if (q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held_q: got %0d expected 0", q);
    end
    n_tests++;
    if (c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_c_out: got %b expected 0", c_out);
    end
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    n_tests++;
    if (q !== 4'd0 || c_out !== 1'b0 || lo_q !== 4'd0 || hi_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: q=%0d c_out=%b lo=%0d hi=%0d expected all 0",
               q, c_out, lo_q, hi_q);
    end
    c_in    = 1'b0;
    casc_en = 1'b0;
  endtask

  // Edges 1..8 on base 9; the base-5 digit wraps along the way.
  task automatic test_count_up();
    c_in    = 1'b1;
    casc_en = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step();
      n_tests++;
      if (q !== 4'(i) || c_out !== 1'b0) begin
        n_fail++;
        $display("FAIL count_up_%0d: q=%0d c_out=%b expected q=%0d c_out=0", i, q, c_out, i);
      end
      n_tests++;
      if (b5_q !== 4'(i % 6) || b5_c_out !== ((i % 6) == 5)) begin
        n_fail++;
        $display("FAIL base5_%0d: q=%0d c_out=%b expected q=%0d c_out=%b",
                 i, b5_q, b5_c_out, i % 6, (i % 6) == 5);
      end
    end
  endtask

  // Continues from test_count_up: 9th edge reaches terminal, 10th wraps.
  task automatic test_carry();
    step();
    n_tests++;
    if (q !== 4'd9 || c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_terminal: q=%0d c_out=%b expected q=9 c_out=1", q, c_out);
    end
    step();
    n_tests++;
    if (q !== 4'd0 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_wrap: q=%0d c_out=%b expected q=0 c_out=0", q, c_out);
    end
    n_tests++;
    if (b5_q !== 4'd4) begin
      n_fail++;
      $display("FAIL base5_after_10: q=%0d expected 4", b5_q);
    end
  endtask

  task automatic test_hold();
    c_in = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (q !== 4'd4) begin
        n_fail++;
        $display("FAIL hold_q4_%0d: q=%0d expected 4", i, q);
      end
    end
    c_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (q !== 4'd9 || c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_reach9: q=%0d c_out=%b expected q=9 c_out=1", q, c_out);
    end
    c_in = 1'b0;
    #1;
    n_tests++;
    if (c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_c_out_gated: c_out=%b expected 0", c_out);
    end
    step();
    n_tests++;
    if (q !== 4'd9 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_q9: q=%0d c_out=%b expected q=9 c_out=0", q, c_out);
    end
  endtask

  task automatic test_async_reset();
    c_in = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    n_tests++;
    if (q !== 4'd7) begin
      n_fail++;
      $display("FAIL async_pre_q7: q=%0d expected 7", q);
    end
    // Drop reset while clk is still high: no edge occurs before sampling.
    #2;
    n_reset = 1'b0;
    #1;
    n_tests++;
    if (q !== 4'd0 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: q=%0d c_out=%b expected q=0 c_out=0", q, c_out);
    end
    @(negedge clk);
    n_reset = 1'b1;
    c_in    = 1'b0;
    #1;
  endtask

  task automatic test_cascade();
    c_in    = 1'b0;
    casc_en = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (lo_q !== 4'd0 || hi_q !== 4'd1) begin
      n_fail++;
      $display("FAIL cascade_10: lo=%0d hi=%0d expected lo=0 hi=1", lo_q, hi_q);
    end
    for (int i = 10; i < 45; i++) step();
    n_tests++;
    if (lo_q !== 4'd5 || hi_q !== 4'd4) begin
      n_fail++;
      $display("FAIL cascade_45: lo=%0d hi=%0d expected lo=5 hi=4", lo_q, hi_q);
    end
    for (int i = 45; i < 99; i++) step();
    n_tests++;
    if (lo_q !== 4'd9 || hi_q !== 4'd9 || hi_c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL cascade_99: lo=%0d hi=%0d c_out=%b expected lo=9 hi=9 c_out=1",
               lo_q, hi_q, hi_c_out);
    end
    step();
    n_tests++;
    if (lo_q !== 4'd0 || hi_q !== 4'd0 || hi_c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade_100: lo=%0d hi=%0d c_out=%b expected lo=0 hi=0 c_out=0",
               lo_q, hi_q, hi_c_out);
    end
    casc_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_reset = 1'b1;
    c_in    = 1'b0;
    casc_en = 1'b0;
    test_reset();
    test_count_up();
    test_carry();
    test_hold();
    test_async_reset();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
